// File: rtl/character_update_sequencer_if.sv
// Signal bundle between the character update sequencer, the game FSM that
// requests ticks, and the character coordinate register file.
interface character_update_sequencer_if;
  logic       start;
  logic [1:0] pacman_dir;
  logic       pacman_move;
  logic [7:0] ghost_dir;
  logic [3:0] ghost_move;
  logic [7:0] rf_x_rd;
  logic [7:0] rf_y_rd;
  logic [7:0] rf_x_wr;
  logic [7:0] rf_y_wr;
  logic [2:0] rf_character_type;
  logic       rf_readwrite;
  logic       busy;
  logic       done;
  logic       collision;
  logic [3:0] collided_ghost;

  modport master (
    input  start, pacman_dir, pacman_move, ghost_dir, ghost_move, rf_x_rd, rf_y_rd,
    output rf_x_wr, rf_y_wr, rf_character_type, rf_readwrite, busy, done,
           collision, collided_ghost
  );

  modport slave (
    output start, pacman_dir, pacman_move, ghost_dir, ghost_move, rf_x_rd, rf_y_rd,
    input  rf_x_wr, rf_y_wr, rf_character_type, rf_readwrite, busy, done,
           collision, collided_ghost
  );
endinterface

// File: rtl/character_update_sequencer.sv
// Per-tick sweep over Pacman and the four ghosts: read coordinates, step and
// clamp them, write them back, then report Pacman/ghost collisions.
module character_update_sequencer #(
  parameter int STEP     = 1,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 159,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 119,
  parameter int HIT_DIST = 4
) (
  input logic clock_50,
  input logic reset,
  character_update_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  localparam logic [2:0] LAST_CHAR = 3'd4;

  state_t     state_q, state_d;
  logic [2:0] index_q, index_d;
  logic [7:0] x_wr_q, x_wr_d;
  logic [7:0] y_wr_q, y_wr_d;
  logic [7:0] new_x_q [5];
  logic [7:0] new_x_d [5];
  logic [7:0] new_y_q [5];
  logic [7:0] new_y_d [5];
  logic       collision_q, collision_d;
  logic [3:0] collided_q, collided_d;

  logic [1:0] cur_dir;
  logic       cur_move;
  logic [7:0] step_x;
  logic [7:0] step_y;
  logic [3:0] hits;

  // Arithmetic is widened to int so a step below zero or past 255 clamps instead of wrapping.
  function automatic logic [7:0] move_axis(input logic [7:0] v, input logic dec,
                                           input logic inc, input int lo, input int hi);
    int t;
    t = int'(v);
    if (dec) t = t - STEP;
    if (inc) t = t + STEP;
    if (t < lo) t = lo;
    if (t > hi) t = hi;
    return t[7:0];
  endfunction

  function automatic logic near(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = -d;
    return d < HIT_DIST;
  endfunction

  always_comb begin
    cur_dir  = bus.pacman_dir;
    cur_move = bus.pacman_move;
    case (index_q)
      3'd1:    begin cur_dir = bus.ghost_dir[1:0]; cur_move = bus.ghost_move[0]; end
      3'd2:    begin cur_dir = bus.ghost_dir[3:2]; cur_move = bus.ghost_move[1]; end
      3'd3:    begin cur_dir = bus.ghost_dir[5:4]; cur_move = bus.ghost_move[2]; end
      3'd4:    begin cur_dir = bus.ghost_dir[7:6]; cur_move = bus.ghost_move[3]; end
      default: ;
    endcase
    step_x = move_axis(bus.rf_x_rd, cur_move && (cur_dir == 2'b10),
                       cur_move && (cur_dir == 2'b11), X_MIN, X_MAX);
    step_y = move_axis(bus.rf_y_rd, cur_move && (cur_dir == 2'b00),
                       cur_move && (cur_dir == 2'b01), Y_MIN, Y_MAX);
    hits = '0;
    for (int k = 1; k < 5; k++) begin
      hits[k-1] = near(new_x_q[0], new_x_q[k]) && near(new_y_q[0], new_y_q[k]);
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    x_wr_d      = x_wr_q;
    y_wr_d      = y_wr_q;
    new_x_d     = new_x_q;
    new_y_d     = new_y_q;
    collision_d = collision_q;
    collided_d  = collided_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          index_d     = '0;
          collision_d = 1'b0;
          collided_d  = '0;
          state_d     = READ;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        x_wr_d = step_x;
        y_wr_d = step_y;
        for (int k = 0; k < 5; k++) begin
          if (index_q == 3'(k)) begin
            new_x_d[k] = step_x;
            new_y_d[k] = step_y;
          end
        end
        state_d = WRITE;
      end
      WRITE: begin
        if (index_q == LAST_CHAR) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 3'd1;
          state_d = READ;
        end
      end
      DONE: begin
        collided_d  = hits;
        collision_d = |hits;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      x_wr_q      <= '0;
      y_wr_q      <= '0;
      collision_q <= 1'b0;
      collided_q  <= '0;
      for (int k = 0; k < 5; k++) begin
        new_x_q[k] <= '0;
        new_y_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      x_wr_q      <= x_wr_d;
      y_wr_q      <= y_wr_d;
      collision_q <= collision_d;
      collided_q  <= collided_d;
      new_x_q     <= new_x_d;
      new_y_q     <= new_y_d;
    end
  end

  // Outside the per-character states the register file sees a harmless read of slot 0.
  assign bus.rf_character_type = (state_q == READ || state_q == CAPTURE || state_q == WRITE)
                                 ? index_q : 3'd0;
  assign bus.rf_readwrite      = (state_q == WRITE);
  assign bus.rf_x_wr           = x_wr_q;
  assign bus.rf_y_wr           = y_wr_q;
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = (state_q == DONE);
  assign bus.collision         = collision_q;
  assign bus.collided_ghost    = collided_q;

endmodule

// File: tb/tb_character_update_sequencer.sv
// Bench for character_update_sequencer: a coordinate register file model, a
// vector table, hand-written corner sequences and randomized ticks vs a model.
module tb_character_update_sequencer;

  logic clock_50 = 1'b0;
  logic reset;

  character_update_sequencer_if bus();

  character_update_sequencer dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_50 = ~clock_50;

  typedef struct {
    int px, py, g1x, g1y;
    logic [1:0] pdir;
    logic       pmove;
    logic [1:0] gdir;
    logic       gmove;
    int epx, epy, eg1x, eg1y;
    int ecoll, ecg;
  } vec_t;

  vec_t vecs [12];

  int total = 0;
  int bad   = 0;

  logic [7:0] rf_x [5];
  logic [7:0] rf_y [5];
  logic       load_en = 1'b0;
  int         load_idx = 0;
  logic [7:0] load_x = '0;
  logic [7:0] load_y = '0;
  int         wr_log [$];
  int         done_cnt = 0;
  int         type_bad = 0;

  int mdl_x [5];
  int mdl_y [5];
  int mdl_cg;

  // Register file: registered read of the addressed slot, write when rw is high.
  always @(posedge clock_50) begin : rf_model
    int t;
    t = int'(bus.rf_character_type);
    if (load_en) begin
      rf_x[load_idx] <= load_x;
      rf_y[load_idx] <= load_y;
    end else if (bus.rf_readwrite) begin
      if (t < 5) begin
        rf_x[t] <= bus.rf_x_wr;
        rf_y[t] <= bus.rf_y_wr;
      end
      wr_log.push_back(t);
    end
    if (t > 4) type_bad <= type_bad + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (t < 5) begin
      bus.rf_x_rd <= rf_x[t];
      bus.rf_y_rd <= rf_y[t];
    end else begin
      bus.rf_x_rd <= '0;
      bus.rf_y_rd <= '0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic setDefaults();
    mdl_x = '{10, 40, 45, 50, 55};
    mdl_y = '{10, 35, 35, 35, 35};
  endtask

  task automatic loadRf();
    for (int i = 0; i < 5; i++) begin
      load_en  = 1'b1;
      load_idx = i;
      load_x   = 8'(mdl_x[i]);
      load_y   = 8'(mdl_y[i]);
      @(negedge clock_50);
    end
    load_en = 1'b0;
  endtask

  // One tick of game rules over the whole cast, applied to mdl_x/mdl_y.
  function automatic void runModel();
    int d, x, y, dx, dy;
    logic m;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        d = int'(bus.pacman_dir);
        m = bus.pacman_move;
      end else begin
        d = int'((bus.ghost_dir >> (2 * (c - 1))) & 8'h3);
        m = bus.ghost_move[c-1];
      end
      x = mdl_x[c];
      y = mdl_y[c];
      if (m) begin
        case (d)
          0:       y = y - 1;
          1:       y = y + 1;
          2:       x = x - 1;
          default: x = x + 1;
        endcase
      end
      mdl_x[c] = (x < 0) ? 0 : (x > 159) ? 159 : x;
      mdl_y[c] = (y < 0) ? 0 : (y > 119) ? 119 : y;
    end
    mdl_cg = 0;
    for (int g = 1; g < 5; g++) begin
      dx = mdl_x[0] - mdl_x[g];
      dy = mdl_y[0] - mdl_y[g];
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      if (dx < 4 && dy < 4) mdl_cg = mdl_cg | (1 << (g - 1));
    end
  endfunction

  task automatic checkModel(input string tag);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("%s_x%0d", tag, i), 32'(rf_x[i]), mdl_x[i]);
      checkOutput($sformatf("%s_y%0d", tag, i), 32'(rf_y[i]), mdl_y[i]);
    end
    checkOutput({tag, "_collided"}, 32'(bus.collided_ghost), mdl_cg);
    checkOutput({tag, "_collision"}, 32'(bus.collision), (mdl_cg != 0) ? 1 : 0);
  endtask

  // Starts a tick from a negedge; optionally pulses start mid-sweep or aborts with reset.
  task automatic applyStimulus(input bit extra_start, input int abort_cycle);
    int base, d0, busy_low, latency;
    bit got_done;
    base     = wr_log.size();
    d0       = done_cnt;
    busy_low = 0;
    latency  = 0;
    got_done = 1'b0;
    bus.start = 1'b1;
    for (int n = 1; n <= 40 && !got_done; n++) begin
      @(negedge clock_50);
      bus.start = extra_start && (n == 3);
      if (n == 1) begin
        checkOutput("busy_after_start", 32'(bus.busy), 1);
        checkOutput("collision_cleared", 32'(bus.collision), 0);
        checkOutput("collided_cleared", 32'(bus.collided_ghost), 0);
      end
      if (n == abort_cycle) begin
        reset = 1'b1;
        @(negedge clock_50);
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_done", 32'(bus.done), 0);
        checkOutput("abort_rw", 32'(bus.rf_readwrite), 0);
        checkOutput("abort_type", 32'(bus.rf_character_type), 0);
        checkOutput("abort_done_count", done_cnt - d0, 0);
        reset = 1'b0;
        return;
      end
      if (!bus.busy) busy_low++;
      if (bus.done) begin
        got_done = 1'b1;
        latency  = n;
      end
    end
    checkOutput("done_seen", 32'(got_done), 1);
    bus.start = extra_start;
    @(negedge clock_50);
    bus.start = 1'b0;
    checkOutput("done_latency", latency, 16);
    checkOutput("busy_gap", busy_low, 0);
    checkOutput("done_width", 32'(bus.done), 0);
    checkOutput("idle_after_done", 32'(bus.busy), 0);
    checkOutput("write_count", wr_log.size() - base, 5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < wr_log.size()) checkOutput($sformatf("write_order%0d", i), wr_log[base+i], i);
    end
    checkOutput("done_count", done_cnt - d0, 1);
    if (extra_start) begin
      repeat (4) @(negedge clock_50);
      checkOutput("start_not_queued", 32'(bus.busy), 0);
      checkOutput("single_done", done_cnt - d0, 1);
    end
  endtask

  initial begin
    vec_t v;
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.pacman_dir  = '0;
    bus.pacman_move = 1'b0;
    bus.ghost_dir   = '0;
    bus.ghost_move  = '0;

    //             px   py  g1x g1y pdir   pm    gdir   gm    epx  epy eg1x eg1y coll cg
    vecs[0]  = '{ 10,  10, 40, 35, 2'b00, 1'b0, 2'b00, 1'b0,  10,  10, 40, 35, 0, 0};
    vecs[1]  = '{ 10,  10, 40, 35, 2'b11, 1'b1, 2'b00, 1'b1,  11,  10, 40, 34, 0, 0};
    vecs[2]  = '{159,   0, 40, 35, 2'b11, 1'b1, 2'b00, 1'b0, 159,   0, 40, 35, 0, 0};
    vecs[3]  = '{159,   0, 40, 35, 2'b00, 1'b1, 2'b00, 1'b0, 159,   0, 40, 35, 0, 0};
    vecs[4]  = '{  0,   5, 40, 35, 2'b10, 1'b1, 2'b00, 1'b0,   0,   5, 40, 35, 0, 0};
    vecs[5]  = '{ 10, 119, 40, 35, 2'b01, 1'b1, 2'b00, 1'b0,  10, 119, 40, 35, 0, 0};
    vecs[6]  = '{ 38,  34, 40, 35, 2'b00, 1'b0, 2'b00, 1'b0,  38,  34, 40, 35, 1, 1};
    vecs[7]  = '{200, 130, 40, 35, 2'b00, 1'b0, 2'b00, 1'b0, 159, 119, 40, 35, 0, 0};
    vecs[8]  = '{ 37,  35, 42, 35, 2'b11, 1'b1, 2'b10, 1'b1,  38,  35, 41, 35, 1, 1};
    vecs[9]  = '{ 36,  35, 40, 35, 2'b00, 1'b0, 2'b00, 1'b0,  36,  35, 40, 35, 0, 0};
    vecs[10] = '{ 10,  10,  0,  0, 2'b00, 1'b0, 2'b01, 1'b1,  10,  10,  0,  1, 0, 0};
    vecs[11] = '{ 10,  10,  0,  0, 2'b00, 1'b0, 2'b00, 1'b1,  10,  10,  0,  0, 0, 0};

    repeat (3) @(negedge clock_50);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    checkOutput("reset_done", 32'(bus.done), 0);
    checkOutput("reset_rw", 32'(bus.rf_readwrite), 0);
    checkOutput("reset_type", 32'(bus.rf_character_type), 0);
    checkOutput("reset_x_wr", 32'(bus.rf_x_wr), 0);
    checkOutput("reset_y_wr", 32'(bus.rf_y_wr), 0);
    checkOutput("reset_collision", 32'(bus.collision), 0);
    checkOutput("reset_collided", 32'(bus.collided_ghost), 0);
    reset = 1'b0;
    @(negedge clock_50);

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      setDefaults();
      mdl_x[0] = v.px;
      mdl_y[0] = v.py;
      mdl_x[1] = v.g1x;
      mdl_y[1] = v.g1y;
      loadRf();
      bus.pacman_dir  = v.pdir;
      bus.pacman_move = v.pmove;
      bus.ghost_dir   = {6'b0, v.gdir};
      bus.ghost_move  = {3'b0, v.gmove};
      applyStimulus(1'b0, 0);
      checkOutput($sformatf("vec%0d_px", i), 32'(rf_x[0]), v.epx);
      checkOutput($sformatf("vec%0d_py", i), 32'(rf_y[0]), v.epy);
      checkOutput($sformatf("vec%0d_g1x", i), 32'(rf_x[1]), v.eg1x);
      checkOutput($sformatf("vec%0d_g1y", i), 32'(rf_y[1]), v.eg1y);
      for (int g = 2; g < 5; g++) begin
        checkOutput($sformatf("vec%0d_g%0dx", i, g), 32'(rf_x[g]), 35 + 5 * g);
        checkOutput($sformatf("vec%0d_g%0dy", i, g), 32'(rf_y[g]), 35);
      end
      checkOutput($sformatf("vec%0d_collision", i), 32'(bus.collision), v.ecoll);
      checkOutput($sformatf("vec%0d_collided", i), 32'(bus.collided_ghost), v.ecg);
      repeat (3) @(negedge clock_50);
      checkOutput($sformatf("vec%0d_collision_held", i), 32'(bus.collision), v.ecoll);
    end

    // start during the sweep and during DONE must be dropped
    setDefaults();
    loadRf();
    bus.pacman_move = 1'b0;
    bus.ghost_move  = '0;
    applyStimulus(1'b1, 0);

    // reset while char 2 is in flight: chars 0-1 already written, 2-4 untouched
    setDefaults();
    loadRf();
    bus.pacman_dir  = 2'b11;
    bus.pacman_move = 1'b1;
    bus.ghost_dir   = 8'hFF;
    bus.ghost_move  = 4'hF;
    applyStimulus(1'b0, 7);
    mdl_x = '{11, 41, 45, 50, 55};
    mdl_y = '{10, 35, 35, 35, 35};
    mdl_cg = 0;
    checkModel("abort");
    @(negedge clock_50);
    runModel();
    applyStimulus(1'b0, 0);
    checkModel("after_abort");

    for (int r = 0; r < 25; r++) begin
      for (int c = 0; c < 5; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          mdl_x[c] = 30 + int'($urandom_range(0, 10));
          mdl_y[c] = 30 + int'($urandom_range(0, 10));
        end else begin
          mdl_x[c] = int'($urandom_range(0, 255));
          mdl_y[c] = int'($urandom_range(0, 255));
        end
      end
      loadRf();
      bus.pacman_dir  = 2'($urandom_range(0, 3));
      bus.pacman_move = 1'($urandom_range(0, 1));
      bus.ghost_dir   = 8'($urandom);
      bus.ghost_move  = 4'($urandom);
      runModel();
      applyStimulus(1'b0, 0);
      checkModel($sformatf("rnd%0d", r));
    end

    checkOutput("type_range", type_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
